position_poll_sched: RTL and testbench

//  Bus-master scheduler for position_peripheral on the J1 peripheral bus (cs/rd/wr/addr/d_in/d_out).

---
 rtl/position_poll_sched_if.sv | 12 +
 rtl/position_poll_sched.sv | 135 +++++++++++++
 tb/tb_position_poll_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/position_poll_sched_if.sv
// Peripheral bus bundle between the poll scheduler (master) and position_peripheral (slave).
interface position_poll_sched_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [15:0] bus_dout;   // write data towards the peripheral d_in
  logic [15:0] bus_din;    // read data from the peripheral d_out, one cycle behind addr

  modport master (output cs, rd, wr, addr, bus_dout, input bus_din);
  modport slave  (input cs, rd, wr, addr, bus_dout, output bus_din);
endinterface

// File: rtl/position_poll_sched.sv
// Periodic measurement scheduler for position_peripheral: start, poll status until idle,
// then read X/Y/THETA into holding registers with a one-cycle valid pulse.
module position_poll_sched #(
  parameter logic [4:0] STATUS_ADDR = 5'd1,
  parameter logic [4:0] START_ADDR  = 5'd0,
  parameter logic [4:0] DATA_ADDR   = 5'd2,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [31:0]           period,
  position_poll_sched_if.master bus,
  output logic [15:0]           pos_x,
  output logic [15:0]           pos_y,
  output logic [15:0]           pos_theta,
  output logic                  valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun
);
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_POLL, S_READ, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] scnt;      // cycles spent in the current state
  logic [31:0]   pcnt;
  logic          run, tick, to_hit;
  logic [15:0]   sh_x, sh_y;

  assign run  = en && (period != 32'd0);
  // >= rather than == so a period shrunk below the running count wraps at once
  assign tick = run && (pcnt >= period - 32'd1);
  assign busy = (state != S_IDLE) && (state != S_WAIT);

  // Period counter: free-runs 0..period-1 while enabled, cleared otherwise
  always_ff @(posedge clk) begin
    if (rst || !run) pcnt <= 32'd0;
    else if (tick)   pcnt <= 32'd0;
    else             pcnt <= pcnt + 32'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Per-state cycle counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst || (state_n != state)) scnt <= '0;
    else                           scnt <= scnt + CW'(1);
  end

  // Next state and bus strobes
  always_comb begin
    state_n      = state;
    to_hit       = 1'b0;
    bus.cs       = 1'b0;
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    bus.addr     = 5'd0;
    bus.bus_dout = 16'h0000;
    case (state)
      S_IDLE: if (en) state_n = S_WAIT;
      S_WAIT: begin
        if (tick)     state_n = S_START;
        else if (!en) state_n = S_IDLE;
      end
      S_START: begin
        bus.cs       = 1'b1;
        bus.wr       = 1'b1;
        bus.addr     = START_ADDR;
        bus.bus_dout = 16'h0001;
        state_n      = S_POLL;
      end
      S_POLL: begin
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = STATUS_ADDR;
        // first cycle still shows data from before the status address was applied
        if ((scnt != '0) && (bus.bus_din == 16'h0000)) begin
          state_n = S_READ;
        end else if (scnt == POLL_LAST) begin
          to_hit  = 1'b1;
          state_n = en ? S_WAIT : S_IDLE;
        end
      end
      S_READ: begin
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = DATA_ADDR + {3'b000, scnt[2:1]};
        if (scnt == READ_LAST) state_n = S_DONE;
      end
      S_DONE:  state_n = en ? S_WAIT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Result capture, valid pulse and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x        <= 16'h0000;
      sh_y        <= 16'h0000;
      pos_x       <= 16'h0000;
      pos_y       <= 16'h0000;
      pos_theta   <= 16'h0000;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick && busy) overrun <= 1'b1;
      if (to_hit)       timeout_err <= 1'b1;
      // each register gets two cycles; its data is present on the second
      if ((state == S_READ) && scnt[0]) begin
        case (scnt[2:1])
          2'd0:    sh_x <= bus.bus_din;
          2'd1:    sh_y <= bus.bus_din;
          default: begin
            pos_x     <= sh_x;
            pos_y     <= sh_y;
            pos_theta <= bus.bus_din;
            valid     <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_position_poll_sched.sv
// Directed bench for position_poll_sched: a registered peripheral model drives read data,
// a transaction-age model predicts every output each cycle, and directed literals pin it.
module tb_position_poll_sched;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] period = 32'd0;
  logic [15:0] pos_x, pos_y, pos_theta;
  logic        valid, busy, timeout_err, overrun;

  position_poll_sched_if bif();

  position_poll_sched dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .bus(bif),
    .pos_x(pos_x), .pos_y(pos_y), .pos_theta(pos_theta),
    .valid(valid), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // peripheral configuration
  int          busy_n = 0;     // status reads answering busy after a start
  bit          stuck  = 1'b0;  // status never goes idle
  logic [15:0] px = 16'h0, py = 16'h0, pt = 16'h0;
  int          busy_left = 0;

  // Peripheral: registered read data, one cycle after the address
  always @(posedge clk) begin
    if (bif.cs && bif.wr && bif.addr == 5'd0 && bif.bus_dout == 16'h0001) busy_left <= busy_n;
    if (bif.cs && bif.rd) begin
      case (bif.addr)
        5'd1: begin
          bif.bus_din <= stuck ? 16'hFFFF : (busy_left > 0 ? 16'h0001 : 16'h0000);
          if (busy_left > 0) busy_left <= busy_left - 1;
        end
        5'd2:    bif.bus_din <= px;
        5'd3:    bif.bus_din <= py;
        5'd4:    bif.bus_din <= pt;
        default: bif.bus_din <= 16'hDEAD;
      endcase
    end else begin
      bif.bus_din <= 16'h0000;
    end
  end

  int total = 0, bad = 0, cyc = 0;
  int nwr = 0, nvalid = 0, npoll = 0, tick_cyc = 0, valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s cycle=%0d got=timeout want=event", name, cyc);
  endtask

  // Model: a transaction is described only by its age since START and its poll length
  int          m_cnt = 0, m_age = -1, m_plen = 0;
  bit          m_on = 1'b0, m_to = 1'b0;
  bit          e_valid = 1'b0, e_tout = 1'b0, e_ovr = 1'b0;
  logic [15:0] e_px = 16'h0, e_py = 16'h0, e_pt = 16'h0;
  int          e_addr, rlast;
  bit          e_cs, e_rd, e_wr, run, tick, nv;

  // Compare against the model on the falling edge, then advance it by one clock
  always @(negedge clk) begin
    rlast  = m_to ? m_plen : m_plen + 6;
    e_cs   = (m_age >= 0) && (m_age <= rlast);
    e_wr   = (m_age == 0);
    e_rd   = (m_age >= 1) && (m_age <= rlast);
    e_addr = 0;
    if (m_age >= 1 && m_age <= m_plen)              e_addr = 1;
    else if (e_rd && m_age > m_plen)                e_addr = 2 + (m_age - m_plen - 1) / 2;
    chk("cs", bif.cs, e_cs);
    chk("rd", bif.rd, e_rd);
    chk("wr", bif.wr, e_wr);
    chk("addr", bif.addr, e_addr);
    chk("bus_dout", bif.bus_dout, e_wr ? 32'd1 : 32'd0);
    chk("busy", busy, m_age >= 0);
    chk("valid", valid, e_valid);
    chk("pos_x", pos_x, e_px);
    chk("pos_y", pos_y, e_py);
    chk("pos_theta", pos_theta, e_pt);
    chk("timeout_err", timeout_err, e_tout);
    chk("overrun", overrun, e_ovr);
    if (bif.cs && bif.wr) nwr++;
    if (bif.cs && bif.rd && bif.addr == 5'd1) npoll++;
    if (valid) begin nvalid++; valid_cyc = cyc; end

    if (rst) begin
      m_cnt = 0; m_age = -1; m_on = 0; m_to = 0;
      e_valid = 0; e_tout = 0; e_ovr = 0; e_px = 0; e_py = 0; e_pt = 0;
    end else begin
      run  = en && (period != 0);
      tick = run && (m_cnt == int'(period) - 1);
      nv   = 1'b0;
      if (m_age >= 0) begin
        if (tick) e_ovr = 1'b1;
        if (m_to && m_age == TIMEOUT) begin
          m_age = -1; m_on = en; e_tout = 1'b1;
        end else if (!m_to && m_age == m_plen + 6) begin
          e_px = px; e_py = py; e_pt = pt; nv = 1'b1; m_age++;
        end else if (!m_to && m_age == m_plen + 7) begin
          m_age = -1; m_on = en;
        end else begin
          m_age++;
        end
      end else if (!m_on) begin
        m_on = en;
      end else if (tick) begin
        m_age = 0; tick_cyc = cyc;
        if (stuck || busy_n + 2 > TIMEOUT) begin m_to = 1; m_plen = TIMEOUT; end
        else begin m_to = 0; m_plen = busy_n + 2; end
      end else if (!en) begin
        m_on = 0;
      end
      e_valid = nv;
      m_cnt = run ? (tick ? 0 : m_cnt + 1) : 0;
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input int want, input string name);
    int v0 = nvalid;
    int k = 0;
    while (nvalid - v0 < want && k < budget) begin step(1); k++; end
    if (nvalid - v0 < want) expire(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  int n0, p0, v0, k;

  initial begin
    // reset state
    step(3);
    chk("rst_cs", bif.cs, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);

    // basic transaction, status idle on the 2nd poll cycle
    rst = 0; busy_n = 0; px = 16'h1234; py = 16'h5678; pt = 16'h9ABC;
    period = 100; en = 1;
    n0 = nwr;
    wait_valid(200, 1, "t1_valid");
    step(2);
    chk("t1_pos_x", pos_x, 16'h1234);
    chk("t1_pos_y", pos_y, 16'h5678);
    chk("t1_pos_theta", pos_theta, 16'h9ABC);
    chk("t1_writes", nwr - n0, 1);
    // START+POLL+READ = 9 cycles; valid is registered into the following cycle
    chk("t1_latency", valid_cyc - tick_cyc, 10);

    // status busy for 50 poll cycles
    busy_n = 49; px = 16'h1111; py = 16'h2222; pt = 16'h3333;
    p0 = npoll; v0 = nvalid;
    wait_valid(250, 1, "t2_valid");
    step(3);
    chk("t2_poll_len", npoll - p0, 51);
    chk("t2_valid_count", nvalid - v0, 1);
    chk("t2_timeout_err", timeout_err, 0);
    chk("t2_pos_x", pos_x, 16'h1111);

    // stuck status: timeout, results kept, next tick retries
    en = 0; step(3);
    period = 1100; stuck = 1; en = 1;
    p0 = npoll; v0 = nvalid;
    k = 0;
    while (!timeout_err && k < 2500) begin step(1); k++; end
    if (!timeout_err) expire("t3_timeout_wait");
    step(2);
    chk("t3_timeout_err", timeout_err, 1);
    chk("t3_poll_len", npoll - p0, 1024);
    chk("t3_pos_x", pos_x, 16'h1111);
    chk("t3_pos_theta", pos_theta, 16'h3333);
    chk("t3_no_valid", nvalid - v0, 0);
    chk("t3_overrun", overrun, 0);
    stuck = 0; busy_n = 0; px = 16'hAAAA; py = 16'hBBBB; pt = 16'hCCCC;
    wait_valid(1300, 1, "t3_retry_valid");
    step(2);
    chk("t3_retry_pos_x", pos_x, 16'hAAAA);

    // 40-cycle transactions against a 5-cycle period
    en = 0; step(3);
    period = 5; busy_n = 30; en = 1;
    v0 = nvalid; n0 = nwr;
    wait_valid(300, 2, "t4_valid");
    chk("t4_overrun", overrun, 1);
    chk("t4_writes", nwr - n0, 2);

    // en dropped during READ: finishes, then idle
    k = 0;
    while (!(bif.rd && bif.addr >= 5'd2) && k < 100) begin step(1); k++; end
    if (!(bif.rd && bif.addr >= 5'd2)) expire("t5_read_wait");
    en = 0;
    v0 = nvalid; n0 = nwr;
    step(60);
    chk("t5_valid", nvalid - v0, 1);
    chk("t5_writes", nwr - n0, 0);
    chk("t5_busy", busy, 0);

    // reset during POLL, then period 0
    busy_n = 200; period = 20; en = 1;
    k = 0;
    while (!(bif.rd && bif.addr == 5'd1) && k < 100) begin step(1); k++; end
    if (!(bif.rd && bif.addr == 5'd1)) expire("t6_poll_wait");
    rst = 1;
    step(1);
    chk("t6_cs", bif.cs, 0);
    chk("t6_rd", bif.rd, 0);
    chk("t6_overrun", overrun, 0);
    period = 0;
    step(1);
    rst = 0;
    n0 = nwr;
    step(300);
    chk("t6_writes", nwr - n0, 0);
    chk("t6_pos_x", pos_x, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
